scan_sequencer: RTL and testbench
=================================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter CNT_W, default 16, width of the dwell input and the internal dwell counter.
REQ-002 Parameter BLANK_CYC, default 2, number of en-low cycles between channels; 0 means no blanking.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to begin scanning, sampled each clock.
REQ-006 stop  input  1  abort request, sampled each clock.
REQ-007 oneshot  input  1  1 = single pass then stop; 0 = continuous.
REQ-008 mask  input  4  channel enable mask; bit i enables channel i.
REQ-009 dwell  input  CNT_W  cycles en stays high per channel; 0 treated as 1.
REQ-010 x  output  2  current channel index; drives the downstream 2-to-4 decoder select.
REQ-011 en  output  1  channel-active strobe; drives the downstream decoder enable.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle pulse at completion of a oneshot pass or a mask-empty termination.

Function
REQ-014 All outputs SHALL be registered; FSM states are IDLE, ACTIVE and BLANK.
REQ-015 IDLE: en=0, busy=0, x holds its last value.
REQ-016 IDLE with start=1 and mask!=0 SHALL enter ACTIVE on the next edge, with x = lowest set mask bit, en=1 and busy=1 in the same cycle.
REQ-017 IDLE with start=1 and mask==0 SHALL remain IDLE with no done pulse.
REQ-018 start while busy SHALL be ignored.
REQ-019 On ACTIVE entry the block SHALL latch dwell (0 -> 1) and clear the counter.
REQ-020 ACTIVE SHALL hold en=1 for exactly the latched dwell cycles.
REQ-021 After the last dwell cycle the next channel SHALL be selected: the next set bit of the current mask strictly above x, wrapping 3 -> 0. The mask is sampled at that edge.
REQ-022 A pass is complete when the next channel search wraps, i.e. next index <= current x.
REQ-023 If oneshot=1 at pass completion, the block SHALL go to IDLE, pulse done for one cycle and drive en=0.
REQ-024 If the sampled mask==0 at a channel transition, the block SHALL go to IDLE and pulse done, regardless of oneshot.
REQ-025 Otherwise, with BLANK_CYC>0, the block SHALL enter BLANK: en=0, x unchanged, for BLANK_CYC cycles, then enter ACTIVE with x = next channel.
REQ-026 Otherwise, with BLANK_CYC==0, the block SHALL enter ACTIVE directly with the new x; en stays 1 across the switch.
REQ-027 A single-channel mask in continuous mode SHALL re-select the same channel every dwell, with BLANK between if BLANK_CYC>0.
REQ-028 stop=1 SHALL override every other event: go to IDLE on the next edge, en=0, no done pulse. stop and start in the same cycle in IDLE SHALL stay IDLE.
REQ-029 x SHALL change only when en=0 or at an ACTIVE->ACTIVE edge, never in the middle of a dwell.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, x=0, en=0, busy=0, done=0 and counters=0, including mid-dwell or mid-blank.
REQ-031 After rst_n deasserts, no activity SHALL occur until start is asserted.

Verification
REQ-032 mask=4'b1111, dwell=3, BLANK_CYC=2, oneshot=1, start pulse -> en high 3 cycles on each of x=0,1,2,3, with 2 en-low cycles between; done pulses once after x=3; busy falls with done.
REQ-033 mask=4'b1010, dwell=2, oneshot=0 -> x sequence 1,3,1,3... repeating; done never pulses.
REQ-034 mask=4'b0000 at start -> busy stays 0 and no done pulse. Mask cleared mid-scan -> IDLE plus one done pulse at the next transition.
REQ-035 dwell=0 -> each channel active exactly 1 cycle. BLANK_CYC=0, mask=4'b1111 -> en continuously 1 and x increments every dwell cycles.
REQ-036 stop asserted mid-dwell on x=2 -> en=0 and busy=0 the next cycle, no done pulse. rst_n pulsed low mid-blank -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/scan_sequencer_if.sv
// rtl/scan_sequencer_if.sv - scan control inputs and decoder drive outputs
interface scan_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             stop;
    logic             oneshot;
    logic [3:0]       mask;
    logic [CNT_W-1:0] dwell;
    logic [1:0]       x;
    logic             en;
    logic             busy;
    logic             done;

    modport slave (
        input  start, stop, oneshot, mask, dwell,
        output x, en, busy, done
    );

    modport master (
        output start, stop, oneshot, mask, dwell,
        input  x, en, busy, done
    );
endinterface

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - masked 4-channel dwell/blank scan sequencer for a 2-to-4 decoder
module scan_sequencer #(
    parameter int CNT_W     = 16,
    parameter int BLANK_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    scan_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;

    localparam int BW = $clog2(BLANK_CYC + 2);

    state_t           state_q, state_d;
    logic [1:0]       x_q, x_d, nxt_q, nxt_d;
    logic             en_q, en_d, busy_q, busy_d, done_q, done_d;
    logic [CNT_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
    logic [BW-1:0]    blank_q, blank_d;

    logic [CNT_W-1:0] dwell_lat;
    logic [1:0]       next_x;
    logic             wrap;
    logic             last_dwell;

    // First set mask bit strictly after cur, wrapping; returns cur itself if only cur is set.
    function automatic logic [1:0] next_ch(input logic [1:0] cur, input logic [3:0] m);
        logic [1:0] r;
        logic [1:0] idx;
        r = cur;
        for (int i = 4; i >= 1; i--) begin
            idx = cur + 2'(i);
            if (m[idx]) r = idx;
        end
        return r;
    endfunction

    assign dwell_lat  = (bus.dwell == '0) ? CNT_W'(1) : bus.dwell;
    assign next_x     = next_ch(x_q, bus.mask);
    assign wrap       = (next_x <= x_q);
    assign last_dwell = (cnt_q == dwell_q - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            nxt_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dwell_q <= '0;
            cnt_q   <= '0;
            blank_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            nxt_q   <= nxt_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            blank_q <= blank_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        nxt_d   = nxt_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        blank_d = blank_q;

        if (bus.stop) begin
            state_d = IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = '0;
            blank_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    en_d   = 1'b0;
                    busy_d = 1'b0;
                    if (bus.start && bus.mask != 4'b0000) begin
                        state_d = ACTIVE;
                        x_d     = next_ch(2'd3, bus.mask);
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                        dwell_d = dwell_lat;
                        cnt_d   = '0;
                    end
                end
                ACTIVE: begin
                    if (!last_dwell) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (bus.mask == 4'b0000 || (wrap && bus.oneshot)) begin
                        state_d = IDLE;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end else if (BLANK_CYC > 0) begin
                        state_d = BLANK;
                        en_d    = 1'b0;
                        nxt_d   = next_x;
                        blank_d = '0;
                        cnt_d   = '0;
                    end else begin
                        x_d     = next_x;
                        dwell_d = dwell_lat;
                        cnt_d   = '0;
                    end
                end
                BLANK: begin
                    if (blank_q == BW'(BLANK_CYC - 1)) begin
                        state_d = ACTIVE;
                        x_d     = nxt_q;
                        en_d    = 1'b1;
                        dwell_d = dwell_lat;
                        cnt_d   = '0;
                        blank_d = '0;
                    end else begin
                        blank_d = blank_q + BW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.x    = x_q;
    assign bus.en   = en_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - scoreboard bench: blanked (2) and unblanked (0) sequencers side by side
module tb_scan_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        oneshot = 1'b0;
    logic [3:0]  mask = 4'b0000;
    logic [15:0] dwell = 16'd0;

    always #5 clk = ~clk;

    scan_sequencer_if #(.CNT_W(16)) b0 ();
    scan_sequencer_if #(.CNT_W(16)) b1 ();

    assign b0.start = start;   assign b1.start = start;
    assign b0.stop = stop;     assign b1.stop = stop;
    assign b0.oneshot = oneshot; assign b1.oneshot = oneshot;
    assign b0.mask = mask;     assign b1.mask = mask;
    assign b0.dwell = dwell;   assign b1.dwell = dwell;

    scan_sequencer #(.CNT_W(16), .BLANK_CYC(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    scan_sequencer #(.CNT_W(16), .BLANK_CYC(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    typedef struct {int x; int len;} seg_t;
    seg_t q0[$];
    seg_t q1[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Monitors: an en-high run with constant x is one segment, compared against the queue head.
    bit mon0 = 0, mon1 = 0;
    int in0 = 0, sx0 = 0, sl0 = 0, gap0 = 0, done0 = 0;
    int in1 = 0, sx1 = 0, sl1 = 0, gap1 = 0, done1 = 0;
    seg_t e0, e1;

    always @(negedge clk) begin
        if (b0.done) done0++;
        if (!mon0) begin
            in0 = 0; gap0 = 0;
        end else begin
            if (b0.done) check("done_busy0", int'(b0.busy), 0);
            if (in0 != 0 && (!b0.en || int'(b0.x) != sx0)) begin
                if (q0.size() == 0) check("unexpected_seg0_x", sx0, -1);
                else begin
                    e0 = q0.pop_front();
                    check("seg0_x", sx0, e0.x);
                    check("seg0_len", sl0, e0.len);
                end
                in0 = 0;
            end
            if (b0.busy && !b0.en) gap0++;
            if (b0.en && in0 == 0) begin
                if (gap0 != 0) check("blank_gap0", gap0, 2);
                gap0 = 0; in0 = 1; sx0 = int'(b0.x); sl0 = 0;
            end
            if (b0.en) sl0++;
        end
    end

    always @(negedge clk) begin
        if (b1.done) done1++;
        if (!mon1) begin
            in1 = 0;
        end else begin
            if (in1 != 0 && (!b1.en || int'(b1.x) != sx1)) begin
                if (q1.size() == 0) check("unexpected_seg1_x", sx1, -1);
                else begin
                    e1 = q1.pop_front();
                    check("seg1_x", sx1, e1.x);
                    check("seg1_len", sl1, e1.len);
                end
                in1 = 0;
            end
            if (b1.busy && !b1.en) gap1++;
            if (b1.en && in1 == 0) begin
                in1 = 1; sx1 = int'(b1.x); sl1 = 0;
            end
            if (b1.en) sl1++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input int x, input int len);
        seg_t s;
        s.x = x; s.len = len;
        q0.push_back(s);
    endtask

    task automatic push1(input int x, input int len);
        seg_t s;
        s.x = x; s.len = len;
        q1.push_back(s);
    endtask

    task automatic pulse_start();
        tick(); start = 1'b1;
        tick(); start = 1'b0;
    endtask

    task automatic wait_q0(input int limit);
        int n = 0;
        while (q0.size() != 0 && n < limit) begin
            @(negedge clk); #1; n++;
        end
        if (q0.size() != 0) check("timeout_q0", q0.size(), 0);
    endtask

    task automatic wait_q1(input int limit);
        int n = 0;
        while (q1.size() != 0 && n < limit) begin
            @(negedge clk); #1; n++;
        end
        if (q1.size() != 0) check("timeout_q1", q1.size(), 0);
    endtask

    task automatic wait_idle0(input int limit);
        int n = 0;
        while (b0.busy && n < limit) begin
            @(negedge clk); #1; n++;
        end
        check("idle_timeout0", int'(b0.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, d1, n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_x0", int'(b0.x), 0);
        check("rst_en0", int'(b0.en), 0);
        check("rst_busy0", int'(b0.busy), 0);
        check("rst_done0", int'(b0.done), 0);
        check("rst_en1", int'(b1.en), 0);
        check("rst_busy1", int'(b1.busy), 0);
        tick(); rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", int'(b0.busy), 0);

        // Oneshot full pass with a start pulse ignored mid-scan.
        mon0 = 1; d0 = done0;
        mask = 4'b1111; dwell = 16'd3; oneshot = 1'b1;
        for (int i = 0; i < 4; i++) push0(i, 3);
        pulse_start();
        repeat (5) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_q0(200);
        wait_idle0(50);
        check("s1_done_count", done0 - d0, 1);
        check("s1_en_after", int'(b0.en), 0);
        mon0 = 0;
        repeat (3) tick();

        // Continuous 1010: 1,3,1,3,1 then stop during blank.
        mon0 = 1; d0 = done0;
        mask = 4'b1010; dwell = 16'd2; oneshot = 1'b0;
        push0(1, 2); push0(3, 2); push0(1, 2); push0(3, 2); push0(1, 2);
        pulse_start();
        wait_q0(200);
        tick(); stop = 1'b1;
        tick(); stop = 1'b0;
        @(negedge clk);
        check("s2_busy_after_stop", int'(b0.busy), 0);
        check("s2_en_after_stop", int'(b0.en), 0);
        check("s2_no_done", done0 - d0, 0);
        mon0 = 0;
        repeat (3) tick();

        // Empty mask at start.
        d0 = done0;
        mask = 4'b0000;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("s3_busy_empty_mask", int'(b0.busy), 0);
        end
        check("s3_no_done", done0 - d0, 0);

        // Mask cleared mid-dwell ends the scan with one done.
        mon0 = 1; d0 = done0;
        mask = 4'b0011; dwell = 16'd4; oneshot = 1'b0;
        push0(0, 4);
        pulse_start();
        tick(); mask = 4'b0000;
        wait_q0(100);
        wait_idle0(50);
        check("s3b_done_count", done0 - d0, 1);
        mon0 = 0;
        repeat (3) tick();

        // Dwell 0 behaves as 1.
        mon0 = 1; d0 = done0;
        mask = 4'b0101; dwell = 16'd0; oneshot = 1'b1;
        push0(0, 1); push0(2, 1);
        pulse_start();
        wait_q0(100);
        wait_idle0(50);
        check("s4_done_count", done0 - d0, 1);
        mon0 = 0;
        repeat (3) tick();

        // Stop mid-dwell on x=2.
        mon0 = 1; d0 = done0;
        mask = 4'b1111; dwell = 16'd5; oneshot = 1'b0;
        push0(0, 5); push0(1, 5); push0(2, 2);
        pulse_start();
        n = 0;
        while (!(b0.en && b0.x == 2'd2) && n < 200) begin
            @(negedge clk); #1; n++;
        end
        check("s5_reached_x2", int'(b0.x), 2);
        tick(); stop = 1'b1;
        tick(); stop = 1'b0;
        @(negedge clk);
        check("s5_en_after_stop", int'(b0.en), 0);
        check("s5_busy_after_stop", int'(b0.busy), 0);
        check("s5_x_holds", int'(b0.x), 2);
        #1;
        wait_q0(10);
        check("s5_no_done", done0 - d0, 0);
        mon0 = 0;
        tick(); start = 1'b1; stop = 1'b1;
        tick(); start = 1'b0; stop = 1'b0;
        @(negedge clk);
        check("s5_start_stop_idle", int'(b0.busy), 0);
        repeat (2) tick();

        // No blanking: en stays high across the whole pass.
        mon1 = 1; gap1 = 0; d1 = done1;
        mask = 4'b1111; dwell = 16'd3; oneshot = 1'b1;
        for (int i = 0; i < 4; i++) push1(i, 3);
        pulse_start();
        wait_q1(200);
        check("s6_gap_cycles", gap1, 0);
        check("s6_done_count", done1 - d1, 1);
        mon1 = 0;
        wait_idle0(100);
        repeat (3) tick();

        // Single channel continuous, then async reset mid-blank.
        mon0 = 1;
        mask = 4'b0100; dwell = 16'd2; oneshot = 1'b0;
        push0(2, 2); push0(2, 2); push0(2, 2);
        pulse_start();
        wait_q0(200);
        mon0 = 0;
        check("s7_in_blank", int'(b0.busy && !b0.en), 1);
        #2 rst_n = 1'b0;
        #1;
        check("s7_rst_x", int'(b0.x), 0);
        check("s7_rst_en", int'(b0.en), 0);
        check("s7_rst_busy", int'(b0.busy), 0);
        check("s7_rst_done", int'(b0.done), 0);
        tick(); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s7_quiet_after_rst", int'(b0.busy) + int'(b0.en), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
